rtc_shadow_regfile: RTL



---
 rtl/rtc_mem_pkg.sv | 31 +++
 rtl/shadow_copy_fsm.sv | 72 +++++++
 rtl/rtc_shadow_regfile.sv | 99 +++++++++
 3 files changed

// File: rtl/rtc_mem_pkg.sv
// Shared types and constants for the RTC shadow register file.
package rtc_mem_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;
  localparam int unsigned DEFAULT_DEPTH  = 16;

  // Word map of the default 16-word bank.
  localparam int unsigned IDX_SEC        = 0;
  localparam int unsigned IDX_MIN        = 1;
  localparam int unsigned IDX_HR         = 2;
  localparam int unsigned IDX_DAY        = 3;
  localparam int unsigned IDX_ALARM_SEC  = 4;
  localparam int unsigned IDX_ALARM_MIN  = 5;
  localparam int unsigned IDX_ALARM_HR   = 6;
  localparam int unsigned IDX_ALARM_DAY  = 7;
  localparam int unsigned IDX_CHRONO_SEC = 8;
  localparam int unsigned IDX_CHRONO_MIN = 9;
  localparam int unsigned IDX_CHRONO_HR  = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    DIR_SNAP    = 1'b0,
    DIR_RESTORE = 1'b1
  } dir_e;

endpackage

// File: rtl/shadow_copy_fsm.sv
// Bulk-copy sequencer: walks idx 0..DEPTH-1 once per command, one word per cycle.
module shadow_copy_fsm
  import rtc_mem_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_snap,
  input  logic              cmd_restore,
  output logic              busy,
  output logic              done,
  output logic              copy_en,
  output logic [ADDR_W-1:0] copy_idx,
  output dir_e              dir
);

  // One spare bit so DEPTH == 2**ADDR_W cannot alias on the final increment.
  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;

  assign copy_idx = idx_q[ADDR_W-1:0];

  // State, index, latched direction and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dir     <= DIR_SNAP;
      busy    <= 1'b0;
      done    <= 1'b0;
      copy_en <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_snap || cmd_restore) begin
            state_q <= COPY;
            idx_q   <= '0;
            // Snap takes priority when both commands arrive together.
            dir     <= cmd_snap ? DIR_SNAP : DIR_RESTORE;
            busy    <= 1'b1;
            copy_en <= 1'b1;
          end
        end
        COPY: begin
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
            done    <= 1'b1;
            copy_en <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          copy_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/rtc_shadow_regfile.sv
// Two-bank register file: live bank written by control, snapshot bank for display/compare.
module rtc_shadow_regfile
  import rtc_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              wr_err,
  input  logic              cmd_snap,
  input  logic              cmd_restore,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] live_q [DEPTH];
  logic [DATA_W-1:0] snap_q [DEPTH];

  logic              copy_en;
  logic [ADDR_W-1:0] copy_idx;
  dir_e              dir;

  logic wr_in_range, rd_a_in_range, rd_b_in_range, wr_accept;

  shadow_copy_fsm #(
    .DEPTH (DEPTH)
  ) u_copy_fsm (
    .clk         (clk),
    .reset       (reset),
    .cmd_snap    (cmd_snap),
    .cmd_restore (cmd_restore),
    .busy        (busy),
    .done        (done),
    .copy_en     (copy_en),
    .copy_idx    (copy_idx),
    .dir         (dir)
  );

  // Address range decode and write qualification.
  always_comb begin
    wr_ready      = ~busy;
    wr_in_range   = 32'(wr_addr) < DEPTH;
    rd_a_in_range = 32'(rd_addr_a) < DEPTH;
    rd_b_in_range = 32'(rd_addr_b) < DEPTH;
    wr_accept     = wr_en && wr_ready && wr_in_range;
  end

  // Bank storage: host writes only when idle, so they never collide with the copy engine.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        live_q[i] <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      if (wr_accept) begin
        live_q[wr_addr] <= wr_data;
      end
      if (copy_en) begin
        if (dir == DIR_SNAP) begin
          snap_q[copy_idx] <= live_q[copy_idx];
        end else begin
          live_q[copy_idx] <= snap_q[copy_idx];
        end
      end
    end
  end

  // Registered read ports; old data is returned on a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      rd_data_a <= rd_a_in_range ? live_q[rd_addr_a] : '0;
      rd_data_b <= rd_b_in_range ? snap_q[rd_addr_b] : '0;
    end
  end

  // Sticky error for writes attempted during a copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_err <= 1'b0;
    end else if (wr_en && busy && wr_in_range) begin
      wr_err <= 1'b1;
    end
  end

endmodule
